// File: rtl/decode_issue_queue.sv
// decode_issue_queue: dual-ported in-order FIFO between decoder and issue.
// Up to two entries are pushed and up to two popped per cycle.
// Every output is decoded from registered state only.

module decode_issue_queue #(
  parameter int  DEPTH  = 8,
  parameter int  DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i_2,
  input  logic [DATA_W-1:0] data_i_2,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o_2,
  output logic [DATA_W-1:0] data_o_2,
  input  logic              ready_i,
  input  logic              ready_i_2,
  output logic [PTR_W:0]    count_o
);

  // ready_o stays high while at least two slots are free.
  localparam logic [PTR_W:0]   FREE2_LIM = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_TWO   = {{(PTR_W-1){1'b0}}, 2'b10};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] storage_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W:0]    count_r;

  logic              ready_s;
  logic              valid_s;
  logic              valid2_s;
  logic [1:0]        push_n_s;
  logic [1:0]        pop_n_s;
  logic              wr0_en_s;
  logic              wr1_en_s;
  logic [DATA_W-1:0] wr0_data_s;
  logic [PTR_W-1:0]  head_p1_s;
  logic [PTR_W-1:0]  tail_p1_s;
  logic [PTR_W:0]    count_next_s;

  assign head_p1_s = head_r + PTR_ONE;
  assign tail_p1_s = tail_r + PTR_ONE;

  // Status flags come straight from the occupancy register.
  always_comb begin
    ready_s  = (count_r <= FREE2_LIM);
    valid_s  = (count_r >= CNT_ONE);
    valid2_s = (count_r >= CNT_TWO);
  end

  // Push decode; a lone second-slot push is compacted into the tail slot.
  always_comb begin
    push_n_s   = 2'd0;
    wr0_en_s   = 1'b0;
    wr1_en_s   = 1'b0;
    wr0_data_s = data_i;
    if (ready_s && !flush_i) begin
      case ({valid_i, valid_i_2})
        2'b11: begin
          push_n_s = 2'd2;
          wr0_en_s = 1'b1;
          wr1_en_s = 1'b1;
        end
        2'b10: begin
          push_n_s = 2'd1;
          wr0_en_s = 1'b1;
        end
        2'b01: begin
          push_n_s   = 2'd1;
          wr0_en_s   = 1'b1;
          wr0_data_s = data_i_2;
        end
        default: begin
          push_n_s = 2'd0;
        end
      endcase
    end else begin
      push_n_s = 2'd0;
    end
  end

  // Pop decode; the second slot only goes together with the first.
  always_comb begin
    pop_n_s = {1'b0, ready_i & valid_s} + {1'b0, ready_i & ready_i_2 & valid2_s};
    count_next_s = count_r + {{(PTR_W-1){1'b0}}, push_n_s}
                           - {{(PTR_W-1){1'b0}}, pop_n_s};
  end

  // Pointer and occupancy state; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else if (flush_i) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else begin
      head_r  <= head_r + {{(PTR_W-2){1'b0}}, pop_n_s};
      tail_r  <= tail_r + {{(PTR_W-2){1'b0}}, push_n_s};
      count_r <= count_next_s;
    end
  end

  // Entry storage is written at tail-relative slots and is never reset.
  always_ff @(posedge clk) begin
    if (wr0_en_s) begin
      storage_r[tail_r] <= wr0_data_s;
    end
    if (wr1_en_s) begin
      storage_r[tail_p1_s] <= data_i_2;
    end
  end

  assign ready_o   = ready_s;
  assign valid_o   = valid_s;
  assign valid_o_2 = valid2_s;
  assign data_o    = storage_r[head_r];
  assign data_o_2  = storage_r[head_p1_s];
  assign count_o   = count_r;

  decode_issue_queue_chk #(
    .PTR_W (PTR_W),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .valid_i_2 (valid_i_2),
    .ready     (ready_s),
    .count     (count_r)
  );

endmodule

// decode_issue_queue_chk: simulation-only protocol and invariant monitor.
module decode_issue_queue_chk #(
  parameter int PTR_W = 3,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush_i,
  input logic           valid_i,
  input logic           valid_i_2,
  input logic           ready,
  input logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  // Flag dropped pushes and any occupancy beyond capacity.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      assert (!((valid_i || valid_i_2) && !ready))
        else $warning("decode_issue_queue: push dropped while fewer than two slots free");
      assert (count <= CNT_MAX)
        else $error("decode_issue_queue: occupancy %0d exceeds depth", count);
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: directed checks of the decode/issue queue.

module tb_decode_issue_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
  localparam int PTR_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i_2;
  logic [DATA_W-1:0] data_i_2;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o_2;
  logic [DATA_W-1:0] data_o_2;
  logic              ready_i;
  logic              ready_i_2;
  logic [PTR_W:0]    count_o;

  int checks = 0;
  int errors = 0;

  decode_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .valid_i_2 (valid_i_2),
    .data_i_2  (data_i_2),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .valid_o_2 (valid_o_2),
    .data_o_2  (data_o_2),
    .ready_i   (ready_i),
    .ready_i_2 (ready_i_2),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic v1, input logic [15:0] d1,
                     input logic v2, input logic [15:0] d2,
                     input logic r1, input logic r2, input logic fl);
    valid_i   = v1;
    data_i    = d1;
    valid_i_2 = v2;
    data_i_2  = d2;
    ready_i   = r1;
    ready_i_2 = r2;
    flush_i   = fl;
    @(posedge clk);
    #1;
    valid_i   = 1'b0;
    valid_i_2 = 1'b0;
    ready_i   = 1'b0;
    ready_i_2 = 1'b0;
    flush_i   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; valid_i_2 = 1'b0;
    data_i = 16'h0; data_i_2 = 16'h0; ready_i = 1'b0; ready_i_2 = 1'b0;
    #12;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_valid2", 32'(valid_o_2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-operation with 5 entries held
    cyc(1'b1, 16'h0101, 1'b1, 16'h0202, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0303, 1'b1, 16'h0404, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0505, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count_o), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count_o), 32'd0);
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    chk("async_rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with double pushes, then a dropped fifth push
    cyc(1'b1, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    chk("fill1_data", 32'(data_o), 32'h0001);
    chk("fill1_data2", 32'(data_o_2), 32'h0002);
    cyc(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0005, 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
    chk("fill3_count", 32'(count_o), 32'd6);
    chk("fill3_ready", 32'(ready_o), 32'd1);
    cyc(1'b1, 16'h0007, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
    chk("fill4_count", 32'(count_o), 32'd8);
    chk("fill4_ready", 32'(ready_o), 32'd0);
    cyc(1'b1, 16'h0009, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    chk("drop_count", 32'(count_o), 32'd8);
    chk("drop_head", 32'(data_o), 32'h0001);
    chk("drop_head2", 32'(data_o_2), 32'h0002);

    // Full drain in pairs
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("drain1_count", 32'(count_o), 32'd6);
    chk("drain1_ready", 32'(ready_o), 32'd1);
    chk("drain1_data", 32'(data_o), 32'h0003);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("drain2_data2", 32'(data_o_2), 32'h0006);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("drain3_data", 32'(data_o), 32'h0007);
    chk("drain3_data2", 32'(data_o_2), 32'h0008);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("drain4_count", 32'(count_o), 32'd0);
    chk("drain4_valid", 32'(valid_o), 32'd0);

    // Order: (A,B),(C,D) drained two at a time
    cyc(1'b1, 16'h000A, 1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h000C, 1'b1, 16'h000D, 1'b0, 1'b0, 1'b0);
    chk("ord_count4", 32'(count_o), 32'd4);
    chk("ord_a", 32'(data_o), 32'h000A);
    chk("ord_b", 32'(data_o_2), 32'h000B);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("ord_count2", 32'(count_o), 32'd2);
    chk("ord_c", 32'(data_o), 32'h000C);
    chk("ord_d", 32'(data_o_2), 32'h000D);
    chk("ord_valid_mid", 32'(valid_o), 32'd1);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("ord_count0", 32'(count_o), 32'd0);
    chk("ord_valid_end", 32'(valid_o), 32'd0);

    // Partial pop: single entry under a double-pop request
    cyc(1'b1, 16'h0055, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("one_count", 32'(count_o), 32'd1);
    chk("one_valid2", 32'(valid_o_2), 32'd0);
    chk("one_data", 32'(data_o), 32'h0055);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("one_pop_count", 32'(count_o), 32'd0);
    chk("one_pop_valid", 32'(valid_o), 32'd0);
    // ready_i_2 alone pops nothing (head=5 tail=5 here)
    cyc(1'b1, 16'h0011, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0033, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("r2only_count", 32'(count_o), 32'd3);
    chk("r2only_data", 32'(data_o), 32'h0011);
    // Single pops across the wrap (slots 5,6,7)
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("pop1_data", 32'(data_o), 32'h0022);
    chk("pop1_data2", 32'(data_o_2), 32'h0033);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("wrapdrain_count", 32'(count_o), 32'd0);

    // Advance pointers to head=4, tail=4 (from 0)
    cyc(1'b1, 16'h00F1, 1'b1, 16'h00F2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00F3, 1'b1, 16'h00F4, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    // count=3 with tail=7, then push (E,F) while popping one
    cyc(1'b1, 16'h0041, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0043, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pre_count", 32'(count_o), 32'd3);
    cyc(1'b1, 16'h00E0, 1'b1, 16'h00F0, 1'b1, 1'b0, 1'b0);
    chk("wrap_count", 32'(count_o), 32'd4);
    chk("wrap_data", 32'(data_o), 32'h0042);
    chk("wrap_data2", 32'(data_o_2), 32'h0043);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("wrap_e", 32'(data_o), 32'h00E0);
    chk("wrap_f", 32'(data_o_2), 32'h00F0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("wrap_end_count", 32'(count_o), 32'd0);

    // Flush priority with count=5 and simultaneous push/pop
    cyc(1'b1, 16'h0061, 1'b1, 16'h0062, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0063, 1'b1, 16'h0064, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0065, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("fl_pre_count", 32'(count_o), 32'd5);
    cyc(1'b1, 16'h0066, 1'b1, 16'h0077, 1'b1, 1'b1, 1'b1);
    chk("fl_count", 32'(count_o), 32'd0);
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_ready", 32'(ready_o), 32'd1);
    cyc(1'b1, 16'h0099, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("fl_g_data", 32'(data_o), 32'h0099);
    chk("fl_g_count", 32'(count_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
